// File: rtl/axi_lite_slave_if.sv
// Shared types and the AXI4-Lite bus interface used by axi_lite_slave.
//   axi_lite_pkg::data_t : 32-bit register/data word
//   axi_lite_if          : AR/R/AW/W/B channel signals
//     modport slave  : responder view (drives ready on AR/AW/W, valid+payload on R/B)
//     modport master : requester view
package axi_lite_pkg;
    typedef logic [31:0] data_t;
endpackage

interface axi_lite_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );

    modport master (
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );
endinterface

// File: rtl/axi_lite_slave.sv
// axi_lite_slave: AXI4-Lite register file of NUM_REGS 32-bit registers,
// one transaction at a time, reads win over simultaneous writes.
//   aclk       : clock, rising edge
//   areset_n   : asynchronous active-low reset
//   s_axi_lite : AXI4-Lite responder port (axi_lite_if.slave)
// Out-of-range accesses (addr >= NUM_REGS*4) answer SLVERR; reads return 0.
module axi_lite_slave
    import axi_lite_pkg::*;
#(
    parameter int    NUM_REGS       = 16,
    parameter data_t RESET_DATA     = 32'hece00593,
    parameter bit    STRB_ZERO_FULL = 1'b1
) (
    input logic       aclk,
    input logic       areset_n,
    axi_lite_if.slave s_axi_lite
);

    localparam int IW = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, RDATA, WDATA, WRESP} state_t;

    state_t        state, state_nxt;
    data_t         regs [NUM_REGS];
    logic [31:0]   aw_addr_q;
    data_t         rdata_q;
    logic [1:0]    rresp_q;
    logic [1:0]    bresp_q;
    logic [3:0]    strb_eff;
    logic          ar_hs, aw_hs, w_hs, r_hs, b_hs;
    logic          arready, awready, wready, rvalid, bvalid;

    function automatic logic in_range(input logic [31:0] a);
        return (a >> (IW + 2)) == 32'd0;
    endfunction

    // Byte-offset bits are ignored by design; tie them off for lint.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{aw_addr_q[1:0], s_axi_lite.araddr[1:0]};

    assign ar_hs = s_axi_lite.arvalid & arready;
    assign aw_hs = s_axi_lite.awvalid & awready;
    assign w_hs  = s_axi_lite.wvalid  & wready;
    assign r_hs  = rvalid & s_axi_lite.rready;
    assign b_hs  = bvalid & s_axi_lite.bready;

    assign strb_eff = (STRB_ZERO_FULL && s_axi_lite.wstrb == 4'b0000) ? 4'b1111
                                                                       : s_axi_lite.wstrb;

    // State register
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ar_hs)      state_nxt = RDATA;
                else if (aw_hs) state_nxt = WDATA;
            end
            RDATA: if (r_hs) state_nxt = IDLE;
            WDATA: if (w_hs) state_nxt = WRESP;
            WRESP: if (b_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs come from state only. areset_n gates the address
    // readies so nothing is accepted while reset is held; awready yields to a
    // concurrent arvalid to give reads priority.
    always_comb begin
        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        rvalid  = 1'b0;
        bvalid  = 1'b0;
        case (state)
            IDLE: begin
                arready = areset_n;
                awready = areset_n & ~s_axi_lite.arvalid;
            end
            RDATA: rvalid = 1'b1;
            WDATA: wready = 1'b1;
            WRESP: bvalid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: read data captured at AR handshake so it is stable through
    // RDATA; register write and bresp captured at W handshake.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            aw_addr_q <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            bresp_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_DATA;
        end else begin
            if (ar_hs) begin
                if (in_range(s_axi_lite.araddr)) begin
                    rdata_q <= regs[s_axi_lite.araddr[IW+1:2]];
                    rresp_q <= RESP_OKAY;
                end else begin
                    rdata_q <= '0;
                    rresp_q <= RESP_SLVERR;
                end
            end
            if (aw_hs) aw_addr_q <= s_axi_lite.awaddr;
            if (w_hs) begin
                if (in_range(aw_addr_q)) begin
                    bresp_q <= RESP_OKAY;
                    for (int b = 0; b < 4; b++)
                        if (strb_eff[b])
                            regs[aw_addr_q[IW+1:2]][8*b +: 8] <= s_axi_lite.wdata[8*b +: 8];
                end else begin
                    bresp_q <= RESP_SLVERR;
                end
            end
        end
    end

    assign s_axi_lite.arready = arready;
    assign s_axi_lite.awready = awready;
    assign s_axi_lite.wready  = wready;
    assign s_axi_lite.rvalid  = rvalid;
    assign s_axi_lite.bvalid  = bvalid;
    assign s_axi_lite.rdata   = rdata_q;
    assign s_axi_lite.rresp   = rresp_q;
    assign s_axi_lite.bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_slave.sv
// Directed self-checking bench for axi_lite_slave (NUM_REGS=16 defaults).
// Inputs are driven on the falling edge; outputs sampled on the falling edge
// (plus a small settle delay) away from the active rising edge.
module tb_axi_lite_slave;

    logic aclk;
    logic areset_n;
    int   checks;
    int   errors;

    axi_lite_if bus();

    axi_lite_slave dut (
        .aclk       (aclk),
        .areset_n   (areset_n),
        .s_axi_lite (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    localparam logic [31:0] RST_VAL = 32'hece00593;

    // ---------------------------------------------------------------- bus tasks
    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] r, output logic lat_ok);
        int n;
        d = 'x; r = 'x; lat_ok = 1'b0;
        @(negedge aclk);
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
        #1;
        n = 0;
        while (bus.arready !== 1'b1 && n < 20) begin @(negedge aclk); #1; n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL ar_timeout addr=%h arready=%b expected 1", a, bus.arready);
            bus.arvalid = 1'b0; bus.rready = 1'b0;
            return;
        end
        @(posedge aclk);
        @(negedge aclk);
        bus.arvalid = 1'b0;
        #1;
        lat_ok = (bus.rvalid === 1'b1);
        d = bus.rdata; r = bus.rresp;
        @(posedge aclk);
        #1 bus.rready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] r,
                             output logic lat_ok);
        int n;
        r = 'x; lat_ok = 1'b0;
        @(negedge aclk);
        bus.awaddr = a; bus.awvalid = 1'b1; bus.bready = 1'b1;
        #1;
        n = 0;
        while (bus.awready !== 1'b1 && n < 20) begin @(negedge aclk); #1; n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL aw_timeout addr=%h awready=%b expected 1", a, bus.awready);
            bus.awvalid = 1'b0; bus.bready = 1'b0;
            return;
        end
        @(posedge aclk);
        @(negedge aclk);
        bus.awvalid = 1'b0;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        #1;
        n = 0;
        while (bus.wready !== 1'b1 && n < 20) begin @(negedge aclk); #1; n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL w_timeout addr=%h wready=%b expected 1", a, bus.wready);
            bus.wvalid = 1'b0; bus.bready = 1'b0;
            return;
        end
        @(posedge aclk);
        @(negedge aclk);
        bus.wvalid = 1'b0;
        #1;
        lat_ok = (bus.bvalid === 1'b1);
        r = bus.bresp;
        @(posedge aclk);
        #1 bus.bready = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        areset_n = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk); #1;
        checks++;
        if (bus.arready !== 1'b0 || bus.awready !== 1'b0 || bus.wready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready ar=%b aw=%b w=%b expected 0 0 0",
                     bus.arready, bus.awready, bus.wready);
        end
        checks++;
        if (bus.rvalid !== 1'b0 || bus.bvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid rvalid=%b bvalid=%b expected 0 0", bus.rvalid, bus.bvalid);
        end
        checks++;
        if (bus.rdata !== 32'h0 || bus.rresp !== 2'b00 || bus.bresp !== 2'b00) begin
            errors++;
            $display("FAIL reset_data rdata=%h rresp=%b bresp=%b expected 0 0 0",
                     bus.rdata, bus.rresp, bus.bresp);
        end
        // arvalid high during reset must not be taken
        bus.arvalid = 1'b1; bus.araddr = 32'h4;
        @(posedge aclk); @(negedge aclk); #1;
        checks++;
        if (bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept rvalid=%b expected 0", bus.rvalid);
        end
        bus.arvalid = 1'b0;
        areset_n = 1'b1;
        #1;
        checks++;
        if (bus.arready !== 1'b1 || bus.awready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready ar=%b aw=%b expected 1 1", bus.arready, bus.awready);
        end
    endtask

    task automatic test_read_reset_value();
        logic [31:0] d; logic [1:0] r; logic lat;
        axi_read(32'h4, d, r, lat);
        checks++;
        if (d !== RST_VAL || r !== 2'b00) begin
            errors++;
            $display("FAIL read_rst_val rdata=%h rresp=%b expected %h 00", d, r, RST_VAL);
        end
        checks++;
        if (lat !== 1'b1) begin
            errors++;
            $display("FAIL read_latency rvalid_at_N+1=%b expected 1", lat);
        end
        #1;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.rdata !== RST_VAL) begin
            errors++;
            $display("FAIL read_hold rvalid=%b rdata=%h expected 0 %h", bus.rvalid, bus.rdata, RST_VAL);
        end
    endtask

    task automatic test_write_full();
        logic [31:0] d; logic [1:0] r; logic lat;
        axi_write(32'h8, 32'hdeadbeef, 4'b1111, r, lat);
        checks++;
        if (r !== 2'b00 || lat !== 1'b1) begin
            errors++;
            $display("FAIL write_full bresp=%b lat=%b expected 00 1", r, lat);
        end
        axi_read(32'h8, d, r, lat);
        checks++;
        if (d !== 32'hdeadbeef || r !== 2'b00) begin
            errors++;
            $display("FAIL readback_full rdata=%h rresp=%b expected deadbeef 00", d, r);
        end
        // low address bits are ignored
        axi_read(32'hB, d, r, lat);
        checks++;
        if (d !== 32'hdeadbeef || r !== 2'b00) begin
            errors++;
            $display("FAIL unaligned_read rdata=%h rresp=%b expected deadbeef 00", d, r);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d; logic [1:0] r; logic lat;
        axi_write(32'hC, 32'h11223344, 4'b0101, r, lat);
        axi_read(32'hC, d, r, lat);
        checks++;
        if (d !== 32'hec220544) begin
            errors++;
            $display("FAIL strobe_0101 rdata=%h expected ec220544", d);
        end
        axi_write(32'hC, 32'h11223344, 4'b0000, r, lat);
        axi_read(32'hC, d, r, lat);
        checks++;
        if (d !== 32'h11223344) begin
            errors++;
            $display("FAIL strobe_zero_full rdata=%h expected 11223344", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d; logic [1:0] r; logic lat;
        axi_read(32'h40, d, r, lat);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            errors++;
            $display("FAIL oor_read rdata=%h rresp=%b expected 0 10", d, r);
        end
        axi_write(32'h40, 32'h55aa55aa, 4'b1111, r, lat);
        checks++;
        if (r !== 2'b10) begin
            errors++;
            $display("FAIL oor_write bresp=%b expected 10", r);
        end
        // 0x40 would alias index 0 if the range check were missing
        axi_read(32'h0, d, r, lat);
        checks++;
        if (d !== RST_VAL || r !== 2'b00) begin
            errors++;
            $display("FAIL oor_no_alias rdata=%h rresp=%b expected %h 00", d, r, RST_VAL);
        end
        axi_read(32'h3C, d, r, lat);
        checks++;
        if (d !== RST_VAL || r !== 2'b00) begin
            errors++;
            $display("FAIL last_reg rdata=%h rresp=%b expected %h 00", d, r, RST_VAL);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d; logic [1:0] r; logic lat;
        @(negedge aclk);
        bus.araddr = 32'h8; bus.arvalid = 1'b1;
        bus.awaddr = 32'h10; bus.awvalid = 1'b1;
        bus.rready = 1'b0; bus.bready = 1'b0;
        #1;
        checks++;
        if (bus.arready !== 1'b1 || bus.awready !== 1'b0) begin
            errors++;
            $display("FAIL coll_priority arready=%b awready=%b expected 1 0", bus.arready, bus.awready);
        end
        @(posedge aclk); @(negedge aclk);
        bus.arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hdeadbeef || bus.awready !== 1'b0) begin
                errors++;
                $display("FAIL coll_r_stall cyc=%0d rvalid=%b rdata=%h awready=%b expected 1 deadbeef 0",
                         i, bus.rvalid, bus.rdata, bus.awready);
            end
            @(negedge aclk);
        end
        bus.rready = 1'b1;
        @(posedge aclk); #1 bus.rready = 1'b0;
        @(negedge aclk); #1;
        checks++;
        if (bus.awready !== 1'b1 || bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL coll_aw_after awready=%b rvalid=%b expected 1 0", bus.awready, bus.rvalid);
        end
        @(posedge aclk); @(negedge aclk);
        bus.awvalid = 1'b0;
        bus.wdata = 32'hcafef00d; bus.wstrb = 4'b1111; bus.wvalid = 1'b1;
        @(posedge aclk); @(negedge aclk);
        bus.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
                errors++;
                $display("FAIL coll_b_stall cyc=%0d bvalid=%b bresp=%b expected 1 00",
                         i, bus.bvalid, bus.bresp);
            end
            @(negedge aclk);
        end
        bus.bready = 1'b1;
        @(posedge aclk); #1 bus.bready = 1'b0;
        @(negedge aclk); #1;
        checks++;
        if (bus.bvalid !== 1'b0) begin
            errors++;
            $display("FAIL coll_b_done bvalid=%b expected 0", bus.bvalid);
        end
        axi_read(32'h10, d, r, lat);
        checks++;
        if (d !== 32'hcafef00d || r !== 2'b00) begin
            errors++;
            $display("FAIL coll_readback rdata=%h rresp=%b expected cafef00d 00", d, r);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d; logic [1:0] r; logic lat;
        @(negedge aclk);
        bus.awaddr = 32'h14; bus.awvalid = 1'b1;
        @(posedge aclk); @(negedge aclk);
        bus.awvalid = 1'b0;
        bus.wdata = 32'h12345678; bus.wstrb = 4'b1111;
        #1;
        checks++;
        if (bus.wready !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_wdata wready=%b expected 1", bus.wready);
        end
        areset_n = 1'b0;
        #1;
        checks++;
        if (bus.wready !== 1'b0 || bus.arready !== 1'b0 || bus.bvalid !== 1'b0) begin
            errors++;
            $display("FAIL abort_async wready=%b arready=%b bvalid=%b expected 0 0 0",
                     bus.wready, bus.arready, bus.bvalid);
        end
        @(negedge aclk);
        areset_n = 1'b1;
        axi_read(32'h14, d, r, lat);
        checks++;
        if (d !== RST_VAL || r !== 2'b00) begin
            errors++;
            $display("FAIL abort_reg rdata=%h rresp=%b expected %h 00", d, r, RST_VAL);
        end
        axi_read(32'h8, d, r, lat);
        checks++;
        if (d !== RST_VAL) begin
            errors++;
            $display("FAIL abort_reset_regs rdata=%h expected %h", d, RST_VAL);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [1:0] r; logic lat;
        axi_write(32'h0, 32'ha5a5_0001, 4'b1111, r, lat);
        axi_write(32'h4, 32'h0000_ff00, 4'b0010, r, lat);
        axi_read(32'h0, d, r, lat);
        checks++;
        if (d !== 32'ha5a50001) begin
            errors++;
            $display("FAIL b2b_reg0 rdata=%h expected a5a50001", d);
        end
        axi_read(32'h4, d, r, lat);
        checks++;
        if (d !== 32'hece0ff93) begin
            errors++;
            $display("FAIL b2b_reg1 rdata=%h expected ece0ff93", d);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        areset_n = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        test_reset();
        test_read_reset_value();
        test_write_full();
        test_strobe();
        test_out_of_range();
        test_collision();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
